// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - fetch program counter with circular return-address stack
//
// Purpose: holds the fetch address and computes the next one from stall,
// return, redirect and sequential requests (in that priority). Calls push the
// link address onto a circular RAS; returns pop it, so the return target needs
// no register-file read.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   reset_addr          boot address, loaded every reset cycle
//   stall               hold pc and RAS, drop all requests
//   redirect_valid/addr branch/jump target
//   call                push link address (only with redirect_valid)
//   ret                 pop RAS and jump to the popped address
//   ret_fallback_addr   return target when the RAS is empty
//   pc                  registered fetch address
//   link_addr           pc + STEP
//   ras_count/empty/full  RAS occupancy
//   ras_overflow/underflow  sticky error flags, cleared by reset only
module pc_ras_unit #(
  parameter int ADDR_W    = 32,
  parameter int STEP      = 4,
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reset_addr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] ret_fallback_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push_req;
  logic              is_empty;
  logic              is_full;

  assign link_addr = pc_q + ADDR_W'(STEP);
  assign push_req  = call & redirect_valid;
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_W'(RAS_DEPTH));

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_ptr  = top_q + PTR_W'(1);

    if (!stall) begin
      if (ret) begin
        if (!is_empty) begin
          pc_d = ras_mem[top_q];
          if (push_req) begin
            // Tail call: replace the popped entry in place, depth unchanged.
            wr_en  = 1'b1;
            wr_ptr = top_q;
          end else begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
          end
        end else begin
          pc_d  = ret_fallback_addr;
          unf_d = 1'b1;
          if (push_req) begin
            wr_en   = 1'b1;
            top_d   = top_q + PTR_W'(1);
            count_d = CNT_W'(1);
          end
        end
      end else if (redirect_valid) begin
        pc_d = redirect_addr;
        if (call) begin
          // When full the pointer wraps onto the oldest entry and overwrites it.
          wr_en = 1'b1;
          top_d = top_q + PTR_W'(1);
          if (is_full) ovf_d = 1'b1;
          else         count_d = count_q + CNT_W'(1);
        end
      end else begin
        pc_d = link_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= reset_addr;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (rst && wr_en) ras_mem[wr_ptr] <= link_addr;
  end

  assign pc            = pc_q;
  assign ras_count     = count_q;
  assign ras_empty     = is_empty;
  assign ras_full      = is_full;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb/tb_pc_ras_unit.sv - self-checking bench for pc_ras_unit
module tb_pc_ras_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reset_addr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        call;
  logic        ret;
  logic [31:0] ret_fallback_addr;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic [3:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;

  pc_ras_unit #(.ADDR_W(32), .STEP(4), .RAS_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .reset_addr(reset_addr), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .call(call), .ret(ret), .ret_fallback_addr(ret_fallback_addr),
    .pc(pc), .link_addr(link_addr), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  // Reference model: the RAS is a plain LIFO list of link addresses, oldest first.
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_ovf;
  logic        m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step(input logic r, input logic st, input logic rv,
                            input logic [31:0] ra, input logic c, input logic rt,
                            input logic [31:0] fb, input logic [31:0] rsa);
    logic [31:0] link;
    logic        push;
    link = m_pc + 32'd4;
    push = c && rv;
    if (!r) begin
      m_pc = rsa;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!st) begin
      if (rt) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin
          m_pc  = fb;
          m_unf = 1'b1;
        end
        if (push) m_ras.push_back(link);
      end else if (rv) begin
        m_pc = ra;
        if (push) begin
          if (m_ras.size() == 8) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(link);
        end
      end else begin
        m_pc = link;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic rv,
                     input logic [31:0] ra, input logic c, input logic rt,
                     input logic [31:0] fb, input logic [31:0] rsa);
    rst = r; stall = st; redirect_valid = rv; redirect_addr = ra;
    call = c; ret = rt; ret_fallback_addr = fb; reset_addr = rsa;
    model_step(r, st, rv, ra, c, rt, fb, rsa);
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("link_addr", link_addr, m_pc + 32'd4);
    chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_ras.size() == 8));
    chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
  endtask

  // Shorthands for the common request shapes.
  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic jump(input logic [31:0] a);
    cyc(1, 0, 1, a, 0, 0, 0, 0);
  endtask
  task automatic do_call(input logic [31:0] a);
    cyc(1, 0, 1, a, 1, 0, 0, 0);
  endtask
  task automatic do_ret(input logic [31:0] fb);
    cyc(1, 0, 0, 0, 0, 1, fb, 0);
  endtask

  initial begin
    m_pc = 0; m_ovf = 0; m_unf = 0;

    // Reset release
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 32'h3FC);
    chk("reset_pc", pc, 32'h3FC);
    chk("reset_link", link_addr, 32'h400);
    chk("reset_empty", 32'(ras_empty), 32'd1);
    idle(); chk("rel_pc1", pc, 32'h400);
    idle(); chk("rel_pc2", pc, 32'h404);
    idle(); chk("rel_pc3", pc, 32'h408);

    // Redirect under stall is dropped
    cyc(1, 1, 1, 32'h800, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h800, 0, 0, 0, 0);
    chk("stall_hold", pc, 32'h408);
    jump(32'h800); chk("redir_pc", pc, 32'h800);
    idle();        chk("redir_seq", pc, 32'h804);

    // Call then return
    jump(32'h500);
    do_call(32'h900);
    chk("call_pc", pc, 32'h900);
    chk("call_cnt", 32'(ras_count), 32'd1);
    idle(); idle();
    do_ret(32'hBAD);
    chk("ret_pc", pc, 32'h504);
    chk("ret_cnt", 32'(ras_count), 32'd0);

    // Overflow, LIFO order, then underflow
    jump(32'h100);
    for (int i = 0; i < 9; i++) do_call(32'h1000 + 32'h10 * i);
    chk("ovf_set", 32'(ras_overflow), 32'd1);
    chk("ovf_full", 32'(ras_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      do_ret(32'hDEAD0);
      chk("lifo_ret", pc, 32'h1000 + 32'h10 * (7 - i) + 32'd4);
    end
    do_ret(32'hDEAD0);
    chk("unf_pc", pc, 32'hDEAD0);
    chk("unf_set", 32'(ras_underflow), 32'd1);

    // Tail call through link
    jump(32'h500);
    do_call(32'h600);
    do_call(32'h680);
    cyc(1, 0, 1, 32'h700, 1, 1, 32'hBAD, 0);
    chk("tail_pc", pc, 32'h604);
    chk("tail_cnt", 32'(ras_count), 32'd2);
    do_ret(32'hBAD);
    chk("tail_top", pc, 32'h684);

    // Reset during stall with a populated stack
    do_call(32'h2200); do_call(32'h2300);
    chk("pre_rst_cnt", 32'(ras_count), 32'd3);
    cyc(0, 1, 1, 32'h9999, 1, 1, 32'h7777, 32'h2000);
    chk("rst_pc", pc, 32'h2000);
    chk("rst_cnt", 32'(ras_count), 32'd0);
    chk("rst_ovf", 32'(ras_overflow), 32'd0);
    chk("rst_unf", 32'(ras_underflow), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        r, st, rv, c, rt;
      logic [31:0] ra, fb, rsa;
      r   = ($urandom_range(0, 59) != 0);
      st  = ($urandom_range(0, 4) == 0);
      rv  = ($urandom_range(0, 1) == 1);
      c   = ($urandom_range(0, 2) == 0);
      rt  = ($urandom_range(0, 4) == 0);
      ra  = $urandom;
      fb  = $urandom;
      rsa = $urandom;
      if (i % 97 < 12) begin
        // bursts of calls to reach and pass full
        st = 0; rv = 1; c = 1; rt = 0; r = 1;
      end
      cyc(r, st, rv, ra, c, rt, fb, rsa);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Holds the fetch address in a register and advances it by STEP each cycle.
- Also accepts stall, branch/jump redirect, and subroutine call/return.
- Call/return use an internal circular return-address stack (RAS), so a return resolves its target without a register-file read.
- Sits between the branch/jump resolution logic and instruction memory; link_addr feeds the register-file write-back for linking instructions.

Parameters:
- ADDR_W, 32, width of all addresses.
- STEP, 4, sequential increment in bytes.
- RAS_DEPTH, 8, number of RAS entries; power of two, >= 2.
- CNT_W, $clog2(RAS_DEPTH+1), width of ras_count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- reset_addr  input  ADDR_W  boot address; loaded into pc every cycle while rst==0.
- stall  input  1  hold pc and RAS; all other requests ignored.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_addr  input  ADDR_W  branch/jump target.
- call  input  1  push link address; only effective with redirect_valid=1.
- ret  input  1  pop RAS and jump to the popped address.
- ret_fallback_addr  input  ADDR_W  return target used when the RAS is empty.
- pc  output  ADDR_W  current fetch address (registered).
- link_addr  output  ADDR_W  pc + STEP (combinational), for linking.
- ras_count  output  CNT_W  number of valid RAS entries.
- ras_empty  output  1  ras_count == 0.
- ras_full  output  1  ras_count == RAS_DEPTH.
- ras_overflow  output  1  sticky: a push happened while full.
- ras_underflow  output  1  sticky: a ret happened while empty.

Behaviour:
- Reset:
  - While rst==0 on a clock edge: pc <= reset_addr, ras_count <= 0, ras_overflow <= 0, ras_underflow <= 0, top pointer <= 0.
  - reset_addr is re-sampled every reset cycle.
  - RAS entry contents are don't-care.
  - Reset overrides stall and all requests, including mid-call/ret.
- Arithmetic:
  - link_addr = pc + STEP, and pc + STEP, truncate to ADDR_W; wrap at 2^ADDR_W is silent.
  - No alignment check is made on redirect_addr.
- Next-pc priority when rst==1 (first match wins):
  1. stall=1: pc holds; RAS, count and flags hold; call, ret and redirect are dropped, so the requester must re-present them.
  2. ret=1: pc <= RAS top if ras_count>0, else pc <= ret_fallback_addr and ras_underflow <= 1. redirect_addr is ignored.
  3. redirect_valid=1: pc <= redirect_addr.
  4. Otherwise: pc <= pc + STEP.
- RAS update when rst==1 and stall==0:
  - Push (call=1 and redirect_valid=1, ret=0):
    - Write link_addr at top+1 and advance top (mod RAS_DEPTH).
    - If not full: ras_count += 1.
    - If full: the oldest entry is overwritten, ras_count stays RAS_DEPTH, ras_overflow <= 1.
  - Pop (ret=1, call=0):
    - If count>0: retreat top and decrement ras_count.
    - If empty: no pointer change.
  - Pop-and-push (ret=1, call=1, redirect_valid=1; tail-call through link):
    - pc <= old top, or the fallback if empty.
    - If non-empty: the top entry is overwritten in place with link_addr and the count is unchanged.
    - If empty: link_addr is pushed, count becomes 1, ras_underflow <= 1.
  - call=1 with redirect_valid=0: call is ignored and the sequential path is used.
- Latency:
  - Requests sampled at edge N take effect on pc after edge N.
  - The popped value is the RAS content before edge N, so a push and a pop in consecutive cycles are coherent.
- Flags: ras_overflow and ras_underflow clear only on reset.

Test Plan:
- Reset release: rst=0 for 3 cycles with reset_addr=0x3FC, then rst=1 -> pc sequence 0x3FC, 0x400, 0x404; ras_empty=1; link_addr=0x400 at pc=0x3FC.
- Redirect/stall: at pc=0x408, redirect_valid=1 with addr 0x800 plus stall=1 for 2 cycles -> pc holds 0x408. Then redirect with stall=0 -> pc=0x800, then 0x804.
- Call/return: at pc=0x500, call and redirect to 0x900 -> pc=0x900, ras_count=1. Three cycles later, ret -> pc=0x504, ras_count=0.
- Overflow (RAS_DEPTH=8): 9 nested calls from pc=0x100 (each calling 0x1000 + 0x10*i), then 9 rets with ret_fallback_addr=0xDEAD0 -> ras_overflow=1 after the 9th call. The first 8 rets return to the last 8 link addresses in LIFO order; the 9th returns 0xDEAD0 and ras_underflow=1.
- Tail-call: with ras_count=2 (top=0x604), ret+call+redirect to 0x700 at pc=0x680 -> pc=0x604, ras_count=2, new top=0x684.
- Reset mid-operation: ras_count=3 and stall=1, then rst=0 for 1 cycle with reset_addr=0x2000 -> pc=0x2000, ras_count=0, both flags 0.
